// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer / commit unit.
package rob_pkg;

    localparam int PREG_W = 7;
    localparam int ARCH_W = 5;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [ARCH_W-1:0] rd;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] pd_old;
    } rob_entry_t;

    // True when tag is strictly younger than ref_tag, ages measured from head modulo DEPTH.
    function automatic logic is_younger(input logic [31:0] tag, input logic [31:0] ref_tag,
                                        input logic [31:0] head, input logic [31:0] idx_mask);
        return ((tag - head) & idx_mask) > ((ref_tag - head) & idx_mask);
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Head/tail pointers with wrap bit; derives occupancy count, full and empty.
module rob_ptr #(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             head_inc,
    input  logic             tail_inc,
    input  logic             flush_valid,
    input  logic [TAG_W-1:0] flush_tag,
    output logic [TAG_W-1:0] head_idx,
    output logic [TAG_W-1:0] tail_idx,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [TAG_W:0] head_reg, head_next;
    logic [TAG_W:0] tail_reg, tail_next;
    logic [TAG_W:0] flush_dist;

    always_comb begin
        flush_dist = {1'b0, flush_tag - head_reg[TAG_W-1:0]};
        head_next  = head_reg + (TAG_W+1)'(head_inc);
        // Rebuilding tail from head keeps the branch inside [head, tail) across a wrap.
        if (flush_valid) begin
            tail_next = head_reg + flush_dist + (TAG_W+1)'(1);
        end else begin
            tail_next = tail_reg + (TAG_W+1)'(tail_inc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    assign head_idx = head_reg[TAG_W-1:0];
    assign tail_idx = tail_reg[TAG_W-1:0];
    assign count    = tail_reg - head_reg;
    assign empty    = (head_reg == tail_reg);
    assign full     = (head_reg[TAG_W-1:0] == tail_reg[TAG_W-1:0]) &&
                      (head_reg[TAG_W] != tail_reg[TAG_W]);

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order single-wide commit, free-list return and mispredict flush.
// Optional retire counter enabled by defining ROB_RETIRE_CNT_EN.
module rob_commit_unit #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int PREG_W = rob_pkg::PREG_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic                      disp_has_dest,
    input  logic [rob_pkg::ARCH_W-1:0] disp_rd,
    input  logic [PREG_W-1:0]         disp_pd_new,
    input  logic [PREG_W-1:0]         disp_pd_old,
    output logic [TAG_W-1:0]          disp_tag,
    input  logic                      wb_valid,
    input  logic [TAG_W-1:0]          wb_tag,
    input  logic                      flush_valid,
    input  logic [TAG_W-1:0]          flush_tag,
    output logic                      commit_valid,
    output logic [rob_pkg::ARCH_W-1:0] commit_rd,
    output logic [PREG_W-1:0]         commit_pd_new,
    output logic                      free_en,
    output logic [PREG_W-1:0]         free_preg,
`ifdef ROB_RETIRE_CNT_EN
    output logic [31:0]               retire_cnt,
`endif
    output logic                      full,
    output logic                      empty
);

    import rob_pkg::*;

    localparam logic [31:0] IDX_MASK = 32'(DEPTH - 1);

    logic [TAG_W-1:0] head_idx, tail_idx;
    logic [TAG_W:0]   count;
    logic [DEPTH-1:0] valid_reg, done_reg;
    logic [DEPTH-1:0] squash;
    logic             disp_fire;
    logic             wb_squashed;
    logic             flush_in_flight;
    rob_entry_t       mem [DEPTH];
    rob_entry_t       head_entry;

    rob_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .head_inc   (commit_valid),
        .tail_inc   (disp_fire),
        .flush_valid(flush_valid),
        .flush_tag  (flush_tag),
        .head_idx   (head_idx),
        .tail_idx   (tail_idx),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
            assign squash[gi] = flush_valid &&
                is_younger(32'(gi), 32'(flush_tag), 32'(head_idx), IDX_MASK);
        end
    endgenerate

    assign wb_squashed     = flush_valid &&
        is_younger(32'(wb_tag), 32'(flush_tag), 32'(head_idx), IDX_MASK);
    assign flush_in_flight = {1'b0, flush_tag - head_idx} < count;
    assign disp_ready      = ~full;
    assign disp_tag        = tail_idx;
    assign disp_fire       = disp_valid & disp_ready & ~flush_valid;

    // Payload lives in the array; valid/done come from the resettable flag vectors.
    always_comb begin
        head_entry       = mem[head_idx];
        head_entry.valid = valid_reg[head_idx];
        head_entry.done  = done_reg[head_idx];
    end

    assign commit_valid  = head_entry.valid & head_entry.done;
    assign commit_rd     = head_entry.rd;
    assign commit_pd_new = head_entry.pd_new;
    assign free_en       = commit_valid & head_entry.has_dest;
    assign free_preg     = head_entry.pd_old;

    always_ff @(posedge clk) begin
        if (disp_fire) begin
            mem[tail_idx] <= '{valid: 1'b1, done: 1'b0, has_dest: disp_has_dest,
                               rd: disp_rd, pd_new: disp_pd_new, pd_old: disp_pd_old};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            done_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid && head_idx == TAG_W'(i)) begin
                    valid_reg[i] <= 1'b0;
                    done_reg[i]  <= 1'b0;
                end else if (squash[i]) begin
                    valid_reg[i] <= 1'b0;
                end else if (disp_fire && tail_idx == TAG_W'(i)) begin
                    valid_reg[i] <= 1'b1;
                    done_reg[i]  <= 1'b0;
                end else if (wb_valid && wb_tag == TAG_W'(i) && valid_reg[i] && !wb_squashed) begin
                    done_reg[i]  <= 1'b1;
                end
            end
        end
    end

`ifdef ROB_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (commit_valid) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

    // Illegal stimulus is flagged here rather than handled.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!flush_valid || flush_in_flight);
            assert (!(wb_valid && valid_reg[wb_tag] && done_reg[wb_tag] && !wb_squashed));
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed plus randomized check of rob_commit_unit against a queue-based reference model.
module tb_rob_commit_unit;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int PREG_W = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              disp_valid = 1'b0, disp_has_dest = 1'b0;
    logic [4:0]        disp_rd = '0;
    logic [PREG_W-1:0] disp_pd_new = '0, disp_pd_old = '0;
    logic              wb_valid = 1'b0, flush_valid = 1'b0;
    logic [TAG_W-1:0]  wb_tag = '0, flush_tag = '0;
    logic              disp_ready, commit_valid, free_en, full, empty;
    logic [TAG_W-1:0]  disp_tag;
    logic [4:0]        commit_rd;
    logic [PREG_W-1:0] commit_pd_new, free_preg;
`ifdef ROB_RETIRE_CNT_EN
    logic [31:0]       retire_cnt;
`endif

    rob_commit_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_has_dest(disp_has_dest),
        .disp_rd(disp_rd), .disp_pd_new(disp_pd_new), .disp_pd_old(disp_pd_old),
        .disp_tag(disp_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pd_new(commit_pd_new),
        .free_en(free_en), .free_preg(free_preg),
`ifdef ROB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       tag;
        bit       has_dest;
        bit [4:0] rd;
        bit [6:0] pd_new;
        bit [6:0] pd_old;
        bit       done;
    } ment_t;

    ment_t       q[$];
    int          head_ptr = 0;
    int unsigned retire_model = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          check_en = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int find(int tag);
        for (int i = 0; i < q.size(); i++) if (q[i].tag == tag) return i;
        return -1;
    endfunction

    task automatic model_clear();
        q.delete();
        head_ptr = 0;
        retire_model = 0;
    endtask

    // Applies one clock edge of the current inputs to the model.
    task automatic model_step();
        bit    cv;
        int    k, p;
        ment_t e;
        cv = (q.size() > 0) && q[0].done;
        p  = flush_valid ? find(int'(flush_tag)) : -1;
        if (wb_valid) begin
            k = find(int'(wb_tag));
            if (k >= 0 && !(flush_valid && k > p)) q[k].done = 1'b1;
        end
        if (flush_valid) begin
            while (q.size() > p + 1) void'(q.pop_back());
        end else if (disp_valid && q.size() < DEPTH) begin
            e.tag = (head_ptr + q.size()) % DEPTH;
            e.has_dest = disp_has_dest;
            e.rd = disp_rd;
            e.pd_new = disp_pd_new;
            e.pd_old = disp_pd_old;
            e.done = 1'b0;
            q.push_back(e);
        end
        if (cv) begin
            void'(q.pop_front());
            head_ptr++;
            retire_model++;
        end
    endtask

    task automatic compare_all();
        bit ecv;
        ecv = (q.size() > 0) && q[0].done;
        chk("disp_ready", 32'(disp_ready), 32'(q.size() < DEPTH));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("disp_tag", 32'(disp_tag), 32'((head_ptr + q.size()) % DEPTH));
        chk("commit_valid", 32'(commit_valid), 32'(ecv));
        chk("free_en", 32'(free_en), 32'(ecv && q[0].has_dest));
        if (ecv) begin
            chk("commit_rd", 32'(commit_rd), 32'(q[0].rd));
            chk("commit_pd_new", 32'(commit_pd_new), 32'(q[0].pd_new));
            chk("free_preg", 32'(free_preg), 32'(q[0].pd_old));
        end
`ifdef ROB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, retire_model);
`endif
    endtask

    always @(negedge clk) if (check_en && !reset) compare_all();

    task automatic cyc();
        @(posedge clk);
        if (!reset) model_step();
        #1;
        disp_valid = 1'b0;
        wb_valid = 1'b0;
        flush_valid = 1'b0;
    endtask

    task automatic set_disp(bit hd, int rd, int pn, int po);
        disp_valid = 1'b1;
        disp_has_dest = hd;
        disp_rd = 5'(rd);
        disp_pd_new = 7'(pn);
        disp_pd_old = 7'(po);
    endtask

    task automatic set_wb(int t);
        wb_valid = 1'b1;
        wb_tag = 4'(t);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int nd[$];
        #1 reset = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check_en = 1;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_free_en", 32'(free_en), 32'd0);

        // Three dispatches, out-of-order completion, in-order retire.
        for (int i = 0; i < 3; i++) begin
            chk("t1_disp_tag", 32'(disp_tag), 32'(i));
            set_disp(1, i + 1, 32 + i, 5 + i);
            cyc();
        end
        set_wb(1); cyc();
        chk("t1_no_commit", 32'(commit_valid), 32'd0);
        set_wb(0); cyc();
        chk("t1_cv0", 32'(commit_valid), 32'd1);
        chk("t1_free0", 32'(free_preg), 32'd5);
        chk("t1_fen0", 32'(free_en), 32'd1);
        set_wb(2); cyc();
        chk("t1_free1", 32'(free_preg), 32'd6);
        cyc();
        chk("t1_free2", 32'(free_preg), 32'd7);
        chk("t1_pd2", 32'(commit_pd_new), 32'd34);
        cyc();
        chk("t1_empty", 32'(empty), 32'd1);

        // Fill to full, reject a 17th, retire a no-dest entry, wrap the tag.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(i != 0, i, 40 + i, 80 + i);
            cyc();
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_ready", 32'(disp_ready), 32'd0);
        set_disp(1, 9, 1, 1); cyc();
        chk("t2_still_full", 32'(full), 32'd1);
        set_wb(0); cyc();
        chk("t3_cv", 32'(commit_valid), 32'd1);
        chk("t3_free_en", 32'(free_en), 32'd0);
        cyc();
        chk("t2_ready_after", 32'(disp_ready), 32'd1);
        chk("t2_wrap_tag", 32'(disp_tag), 32'd0);

        // Flush with a squashed writeback in the same cycle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_disp(1, i, 20 + i, 10 + i);
            cyc();
        end
        flush_valid = 1'b1; flush_tag = 4'd2; set_wb(4); cyc();
        chk("t4_tail", 32'(disp_tag), 32'd3);
        set_disp(1, 3, 50, 13); cyc();
        set_disp(1, 4, 51, 14); cyc();
        set_wb(0); cyc();

        // Head commit, writeback of the next head and a flush, all in one cycle.
        set_wb(1); flush_valid = 1'b1; flush_tag = 4'd3; cyc();
        chk("t5_cv", 32'(commit_valid), 32'd1);
        chk("t5_free", 32'(free_preg), 32'd11);
        chk("t5_tail", 32'(disp_tag), 32'd4);
        cyc();
        chk("t5_cv_after", 32'(commit_valid), 32'd0);

        // Asynchronous reset with work in flight.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_disp(1, i, 60 + i, 70 + i);
            cyc();
        end
        set_wb(0); cyc();
        chk("t6_cv_before", 32'(commit_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_cv", 32'(commit_valid), 32'd0);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomized traffic; alternating phases favour filling and draining.
        for (int n = 0; n < 4000; n++) begin
            int wb_pct;
            wb_pct = ((n / 400) % 2 == 0) ? 70 : 20;
            disp_valid = ($urandom_range(0, 3) != 0);
            disp_has_dest = ($urandom_range(0, 3) != 0);
            disp_rd = 5'($urandom);
            disp_pd_new = 7'($urandom);
            disp_pd_old = 7'($urandom);
            nd.delete();
            foreach (q[i]) if (!q[i].done) nd.push_back(q[i].tag);
            if (nd.size() > 0 && $urandom_range(0, 99) < wb_pct) begin
                set_wb(nd[$urandom_range(0, nd.size() - 1)]);
            end else if (q.size() < DEPTH && $urandom_range(0, 9) == 0) begin
                set_wb((head_ptr + q.size() + $urandom_range(0, DEPTH - 1 - q.size())) % DEPTH);
            end
            if (q.size() > 0 && $urandom_range(0, 29) == 0) begin
                flush_valid = 1'b1;
                flush_tag = 4'(q[$urandom_range(0, q.size() - 1)].tag);
            end
            cyc();
        end

        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer plus in-order commit stage for the OoO RISC-V core.
- Dispatch (rename) writes one entry per cycle carrying the newly allocated pd and the displaced pd_old.
- Execution writeback marks entries done. The head commits in order, one per cycle.
- On commit it drives the physical-register free list's write port with pd_old, so retired mappings return to the pool.
- Branch mispredict flushes every entry younger than the branch.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of two.
- TAG_W, $clog2(DEPTH), ROB tag width.
- PREG_W, 7, physical register id width (128 pregs).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available (= !full)
- disp_has_dest  in  1  instruction writes rd (rd != x0)
- disp_rd  in  5  architectural destination
- disp_pd_new  in  PREG_W  newly allocated preg
- disp_pd_old  in  PREG_W  previous mapping of rd
- disp_tag  out  TAG_W  tag assigned to this dispatch (= tail index)
- wb_valid  in  1  completion strobe
- wb_tag  in  TAG_W  tag of completing instruction
- flush_valid  in  1  mispredict
- flush_tag  in  TAG_W  tag of the mispredicted branch (branch itself kept)
- commit_valid  out  1  head retires this cycle
- commit_rd  out  5  retiring rd
- commit_pd_new  out  PREG_W  retiring pd (for the arch map)
- free_en  out  1  commit_valid & head.has_dest (to free list write_en)
- free_preg  out  PREG_W  head.pd_old (to free list data_in)
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Pointers: head/tail are TAG_W+1 bits; the MSB is the wrap bit. full = idx equal & wrap differ; empty = pointers equal.
- Reset (async):
  - head = tail = 0; all valid/done bits cleared.
  - Outputs: commit_valid = free_en = 0, empty = 1, full = 0, disp_ready = 1.
  - Entry payload is not reset.
- Dispatch fires on disp_valid & disp_ready:
  - Writes {has_dest, rd, pd_new, pd_old}, sets valid = 1, done = 0; tail++.
  - disp_tag is combinational from the current tail.
- Writeback: wb_valid sets done[wb_tag] at the clock edge. Writeback to an entry with valid = 0 is ignored.
- Commit:
  - commit_valid = valid[head] & done[head], combinational from registered state (zero-latency visibility, one commit per cycle).
  - On commit: valid[head] cleared; head++ at the edge.
  - A writeback to the head tag commits no earlier than the next cycle.
- Simultaneous dispatch + commit when full: disp_ready is 0; no bypass.
- Flush:
  - tail <= flush_tag + 1, with the wrap bit chosen so the branch stays within [head, tail).
  - valid cleared for all entries strictly younger than flush_tag; dispatch ignored that cycle.
  - A commit in the same cycle still proceeds.
  - Writebacks in the flush cycle to squashed tags are dropped.
- Wrap-around: indices modulo DEPTH; tag DEPTH-1 is followed by 0.
- Illegal inputs (flush_tag not in flight, wb to an already-done entry) are caught by assertions, not handled.

Optional Feature:
- Macro ROB_RETIRE_CNT_EN.
- Defined: adds output retire_cnt [31:0], reset 0, incremented on each commit_valid, wraps at 2^32.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- rob_pkg holds PREG_W, ARCH_W = 5, the rob_entry_t struct {valid, done, has_dest, rd, pd_new, pd_old}, and a helper function for the age compare (is_younger).
- One sub-module, rob_ptr, owns the head/tail wrap-bit pointers and the full/empty/count logic.

Test Plan:
- Reset, then dispatch 3 entries (pd_new 32,33,34; pd_old 5,6,7); wb tags 1,0,2 -> commits in order 0,1,2 on consecutive cycles; free_preg = 5,6,7 with free_en = 1.
- Dispatch 16 -> full = 1, disp_ready = 0; a 17th disp_valid is ignored. Commit one -> disp_ready = 1 next cycle; the next tag assigned is 0 (wrap).
- Entry with disp_has_dest = 0 commits -> commit_valid = 1, free_en = 0.
- 6 in flight (tags 0-5), flush_tag = 2 -> tail index 3, tags 3-5 squashed; the next dispatch gets tag 3; wb to tag 4 in the flush cycle has no effect.
- wb_tag = head tag and flush in the same cycle as a head commit -> head commit completes; the newly done entry retires the following cycle.
- Assert reset mid-stream with 5 entries in flight -> immediately empty = 1, commit_valid = 0, with no clock edge needed.
